// File: rtl/hdmi_out_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdmi_out_pkg
// Description : Types and default timing constants shared by the HDMI
//               output path (line fetch sequencer and timing generator).
//               - fetch_state_t  : IDLE / ARMED / REQ sequencer states
//               - DEF_LINES      : active lines per frame
//               - DEF_LINE_BYTES : byte stride between line start addresses
// Revision    : 1.0 - initial release
// ============================================================================
package hdmi_out_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_REQ   = 2'd2
  } fetch_state_t;

  localparam int DEF_LINES      = 720;
  localparam int DEF_LINE_BYTES = 5120;  // 1280 px x 4 B

endpackage : hdmi_out_pkg
`default_nettype wire

// File: rtl/line_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : line_fetch_ctrl
// Description : Frame/line fetch sequencer. Turns vsync/hsync edge pulses
//               into one framebuffer read request per active line using a
//               req/ack handshake, tracks the line count and flags
//               underrun / short-frame errors.
// Ports       :
//   clk           in   pixel-domain clock
//   rst_n         in   asynchronous active-low reset
//   enable_I      in   sequencer runs while high
//   frame_I       in   vsync edge pulse (1 cycle)
//   line_I        in   hsync edge pulse (1 cycle)
//   fb_base_I     in   framebuffer base, sampled on an accepted frame_I
//   clr_I         in   clears sticky error flags
//   req_O         out  line fetch request
//   req_addr_O    out  start address of requested line (stable while req_O)
//   ack_I         in   reader accepts the request
//   line_cnt_O    out  lines completed in the current frame
//   frame_done_O  out  pulse after the last line of a frame is acked
//   underrun_O    out  sticky: line_I arrived while a request was pending
//   short_frame_O out  sticky: frame_I arrived before the frame completed
// Revision    : 1.0 - initial release
// ============================================================================
module line_fetch_ctrl
  import hdmi_out_pkg::*;
#(
  parameter int LINES      = DEF_LINES,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int ADDR_W     = 32,
  parameter int CNT_W      = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable_I,
  input  logic              frame_I,
  input  logic              line_I,
  input  logic [ADDR_W-1:0] fb_base_I,
  input  logic              clr_I,
  output logic              req_O,
  output logic [ADDR_W-1:0] req_addr_O,
  input  logic              ack_I,
  output logic [CNT_W-1:0]  line_cnt_O,
  output logic              frame_done_O,
  output logic              underrun_O,
  output logic              short_frame_O
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [ADDR_W-1:0] shadow, shadow_nxt;
  logic              frame_pend, frame_pend_nxt;
  logic              req_nxt;
  logic [ADDR_W-1:0] req_addr_nxt;
  logic [CNT_W-1:0]  line_cnt_nxt;
  logic              frame_done_nxt;
  logic              underrun_set, short_set;
  logic              underrun_nxt, short_frame_nxt;

  // A frame pulse landing on the very cycle of the ack is treated exactly
  // like one that arrived earlier in REQ, so it is never lost.
  logic              pend_eff;
  logic [ADDR_W-1:0] shadow_eff;

  assign pend_eff   = frame_pend | frame_I;
  assign shadow_eff = frame_I ? fb_base_I : shadow;

  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr;
    shadow_nxt     = shadow;
    frame_pend_nxt = frame_pend;
    req_nxt        = req_O;
    req_addr_nxt   = req_addr_O;
    line_cnt_nxt   = line_cnt_O;
    frame_done_nxt = 1'b0;
    underrun_set   = 1'b0;
    short_set      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (frame_I && enable_I) begin
          addr_nxt     = fb_base_I;
          line_cnt_nxt = '0;
          state_nxt    = ST_ARMED;
        end
      end

      ST_ARMED: begin
        if (!enable_I) begin
          state_nxt = ST_IDLE;
        end else if (frame_I) begin
          // Only reachable mid-frame: a full frame already returned to IDLE.
          short_set    = 1'b1;
          addr_nxt     = fb_base_I;
          line_cnt_nxt = '0;
        end else if (line_I) begin
          req_nxt      = 1'b1;
          req_addr_nxt = addr;
          state_nxt    = ST_REQ;
        end
      end

      ST_REQ: begin
        if (line_I) begin
          underrun_set = 1'b1;
        end
        if (frame_I) begin
          frame_pend_nxt = 1'b1;
          shadow_nxt     = fb_base_I;
        end
        if (ack_I) begin
          req_nxt = 1'b0;
          if (pend_eff) begin
            addr_nxt       = shadow_eff;
            line_cnt_nxt   = '0;
            frame_pend_nxt = 1'b0;
            state_nxt      = ST_ARMED;
            // Count before this ack below LINES-1 means the frame is cut short.
            if (line_cnt_O < CNT_W'(LINES - 1)) begin
              short_set = 1'b1;
            end
          end else begin
            addr_nxt     = addr + ADDR_W'(LINE_BYTES);
            line_cnt_nxt = line_cnt_O + 1'b1;
            if (line_cnt_O == CNT_W'(LINES - 1)) begin
              frame_done_nxt = 1'b1;
              state_nxt      = ST_IDLE;
            end else begin
              state_nxt = ST_ARMED;
            end
          end
          if (!enable_I) begin
            state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // Sticky flags: a set in the same cycle as clear wins.
    underrun_nxt    = underrun_set | (underrun_O & ~clr_I);
    short_frame_nxt = short_set | (short_frame_O & ~clr_I);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      addr          <= '0;
      shadow        <= '0;
      frame_pend    <= 1'b0;
      req_O         <= 1'b0;
      req_addr_O    <= '0;
      line_cnt_O    <= '0;
      frame_done_O  <= 1'b0;
      underrun_O    <= 1'b0;
      short_frame_O <= 1'b0;
    end else begin
      state         <= state_nxt;
      addr          <= addr_nxt;
      shadow        <= shadow_nxt;
      frame_pend    <= frame_pend_nxt;
      req_O         <= req_nxt;
      req_addr_O    <= req_addr_nxt;
      line_cnt_O    <= line_cnt_nxt;
      frame_done_O  <= frame_done_nxt;
      underrun_O    <= underrun_nxt;
      short_frame_O <= short_frame_nxt;
    end
  end

endmodule : line_fetch_ctrl
`default_nettype wire

// File: tb/tb_line_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_fetch_ctrl
// Description : Directed self-checking bench for line_fetch_ctrl. A 32-bit
//               address instance and an 8-bit address instance share all
//               stimulus; the 8-bit one exercises address wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_fetch_ctrl;

  localparam int C_LINES      = 4;
  localparam int C_LINE_BYTES = 16;
  localparam int C_CNT_W      = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        frame;
  logic        line;
  logic [31:0] fb_base;
  logic [7:0]  fb_base_w;
  logic        clr;
  logic        ack;

  logic               req, req_w;
  logic [31:0]        req_addr;
  logic [7:0]         req_addr_w;
  logic [C_CNT_W-1:0] line_cnt, line_cnt_w;
  logic               frame_done, frame_done_w;
  logic               underrun, underrun_w;
  logic               short_frame, short_frame_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign fb_base_w = fb_base[7:0];

  line_fetch_ctrl #(
    .LINES(C_LINES), .LINE_BYTES(C_LINE_BYTES), .ADDR_W(32), .CNT_W(C_CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable_I(enable), .frame_I(frame),
    .line_I(line), .fb_base_I(fb_base), .clr_I(clr), .req_O(req),
    .req_addr_O(req_addr), .ack_I(ack), .line_cnt_O(line_cnt),
    .frame_done_O(frame_done), .underrun_O(underrun),
    .short_frame_O(short_frame)
  );

  line_fetch_ctrl #(
    .LINES(C_LINES), .LINE_BYTES(C_LINE_BYTES), .ADDR_W(8), .CNT_W(C_CNT_W)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .enable_I(enable), .frame_I(frame),
    .line_I(line), .fb_base_I(fb_base_w), .clr_I(clr), .req_O(req_w),
    .req_addr_O(req_addr_w), .ack_I(ack), .line_cnt_O(line_cnt_w),
    .frame_done_O(frame_done_w), .underrun_O(underrun_w),
    .short_frame_O(short_frame_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame(input logic [31:0] base);
    frame   = 1'b1;
    fb_base = base;
    tick();
    frame   = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // hsync pulse, check request, hold for wait_cycles, then ack.
  task automatic do_line(input string tag, input logic [31:0] exp_addr, input int wait_cycles);
    line = 1'b1;
    tick();
    line = 1'b0;
    check({tag, "_req"}, {31'd0, req}, 32'd1);
    check({tag, "_addr"}, req_addr, exp_addr);
    check({tag, "_addr_w"}, {24'd0, req_addr_w}, exp_addr & 32'hFF);
    repeat (wait_cycles) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check({tag, "_req_drop"}, {31'd0, req}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; frame = 1'b0; line = 1'b0;
    fb_base = 32'd0; clr = 1'b0; ack = 1'b0;
    repeat (2) tick();

    // Reset state
    check("rst_req", {31'd0, req}, 32'd0);
    check("rst_addr", req_addr, 32'd0);
    check("rst_cnt", {29'd0, line_cnt}, 32'd0);
    check("rst_flags", {29'd0, frame_done, underrun, short_frame}, 32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();

    // Normal frame: 0x1000, 0x1010, 0x1020, 0x1030
    pulse_frame(32'h1000);
    check("nf_cnt0", {29'd0, line_cnt}, 32'd0);
    for (int i = 0; i < C_LINES; i++) begin
      do_line("nf", 32'h1000 + 32'(16 * i), 1);
      check("nf_cnt", {29'd0, line_cnt}, 32'(i + 1));
      check("nf_done", {31'd0, frame_done}, (i == C_LINES - 1) ? 32'd1 : 32'd0);
    end
    tick();
    check("nf_done_1cyc", {31'd0, frame_done}, 32'd0);
    line = 1'b1; tick(); line = 1'b0;
    check("idle_ignores_line", {31'd0, req}, 32'd0);
    check("nf_flags", {30'd0, underrun, short_frame}, 32'd0);

    // Underrun: line pulse while request outstanding
    pulse_frame(32'h1000);
    line = 1'b1; tick(); line = 1'b0;
    check("ur_req", {31'd0, req}, 32'd1);
    tick();
    line = 1'b1; tick(); line = 1'b0;
    check("ur_flag", {31'd0, underrun}, 32'd1);
    check("ur_addr_hold", req_addr, 32'h1000);
    repeat (2) tick();
    ack = 1'b1; tick(); ack = 1'b0;
    repeat (3) tick();
    check("ur_no_extra_req", {31'd0, req}, 32'd0);
    do_line("ur_next", 32'h1010, 1);
    check("ur_cnt", {29'd0, line_cnt}, 32'd2);

    // Clear flags, then short frame from ARMED after 2 lines
    pulse_clr();
    check("clr_underrun", {31'd0, underrun}, 32'd0);
    pulse_frame(32'h3000);
    check("sf_flag", {31'd0, short_frame}, 32'd1);
    check("sf_cnt", {29'd0, line_cnt}, 32'd0);
    do_line("sf_next", 32'h3000, 1);

    // Simultaneous frame+line in ARMED: restart, no request
    pulse_clr();
    check("clr_short", {31'd0, short_frame}, 32'd0);
    frame = 1'b1; line = 1'b1; fb_base = 32'h4000;
    tick();
    frame = 1'b0; line = 1'b0;
    check("fl_no_req", {31'd0, req}, 32'd0);
    check("fl_short", {31'd0, short_frame}, 32'd1);
    check("fl_cnt", {29'd0, line_cnt}, 32'd0);
    do_line("fl_next", 32'h4000, 1);

    // Frame during REQ with new base 0x2000
    pulse_clr();
    line = 1'b1; tick(); line = 1'b0;
    check("fr_req", {31'd0, req}, 32'd1);
    check("fr_addr", req_addr, 32'h4010);
    pulse_frame(32'h2000);
    check("fr_req_hold", {31'd0, req}, 32'd1);
    check("fr_addr_hold", req_addr, 32'h4010);
    check("fr_no_short_yet", {31'd0, short_frame}, 32'd0);
    ack = 1'b1; tick(); ack = 1'b0;
    check("fr_req_drop", {31'd0, req}, 32'd0);
    check("fr_short", {31'd0, short_frame}, 32'd1);
    check("fr_cnt", {29'd0, line_cnt}, 32'd0);
    check("fr_no_done", {31'd0, frame_done}, 32'd0);

    // Next request uses new base; clear and set in same cycle -> set wins
    line = 1'b1; tick(); line = 1'b0;
    check("fr_next_addr", req_addr, 32'h2000);
    clr = 1'b1; line = 1'b1; tick(); clr = 1'b0; line = 1'b0;
    check("clr_vs_set_ur", {31'd0, underrun}, 32'd1);
    check("clr_short_same", {31'd0, short_frame}, 32'd0);
    ack = 1'b1; tick(); ack = 1'b0;

    // Async reset mid-request
    line = 1'b1; tick(); line = 1'b0;
    check("ar_req", {31'd0, req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_req_drop", {31'd0, req}, 32'd0);
    check("ar_addr", req_addr, 32'd0);
    check("ar_cnt", {29'd0, line_cnt}, 32'd0);
    check("ar_flags", {30'd0, underrun, short_frame}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    line = 1'b1; tick(); line = 1'b0;
    check("ar_idle", {31'd0, req}, 32'd0);

    // Address wrap: 8-bit instance goes 0xF8 -> 0x08
    pulse_frame(32'hF8);
    do_line("wr0", 32'hF8, 0);
    do_line("wr1", 32'h108, 2);
    check("wr_cnt_w", {29'd0, line_cnt_w}, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule : tb_line_fetch_ctrl
`default_nettype wire
